// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared FSM states, parity mode constants and parameter check for the UART receiver

package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  function automatic bit params_legal(input int data_bits, input int oversample,
                                      input int parity_mode, input int stop_bits);
    return (data_bits >= 5) && (data_bits <= 9) &&
           (oversample >= 8) && (oversample <= 32) && ((oversample % 2) == 0) &&
           (parity_mode >= PAR_NONE) && (parity_mode <= PAR_ODD) &&
           ((stop_bits == 1) || (stop_bits == 2));
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - rx synchronizer, 3-sample majority vote and tick-aligned falling-edge detect

module uart_rx_sampler
  import uart_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic sample_tick,
  input  logic rx,
  output logic vote,
  output logic fall
);

  logic       meta;
  logic       rx_sync;
  logic [1:0] hist;

  // hist holds the two previous tick samples; the vote uses them plus the current one
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta    <= 1'b1;
      rx_sync <= 1'b1;
      hist    <= 2'b11;
    end else begin
      meta    <= rx;
      rx_sync <= meta;
      if (sample_tick) hist <= {hist[0], rx_sync};
    end
  end

  assign vote = (hist[1] & hist[0]) | (hist[1] & rx_sync) | (hist[0] & rx_sync);
  assign fall = sample_tick & hist[0] & ~rx_sync;

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - oversampling UART receive controller; UART_RX_BREAK_DET_EN adds break_det

module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 sample_tick,
  input  logic                 rx,
  output logic                 shift,
  output logic                 parity_check,
  output logic                 chk_stop,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err
`ifdef UART_RX_BREAK_DET_EN
  ,
  output logic                 break_det
`endif
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] HALF_M1   = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_M1   = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
  localparam logic          ODD_INV   = logic'(PARITY_MODE == PAR_ODD);
  localparam bit            PARAMS_OK = params_legal(DATA_BITS, OVERSAMPLE, PARITY_MODE, STOP_BITS);

  if (!PARAMS_OK) begin : g_param_error
    $error("uart_rx_ctrl: illegal parameter set");
  end

  rx_state_t            state, state_n;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_acc, frm_acc;
  logic                 vote, fall, at_bit, start_frame, done;

  uart_rx_sampler u_sampler (
    .clk         (clk),
    .reset_n     (reset_n),
    .sample_tick (sample_tick),
    .rx          (rx),
    .vote        (vote),
    .fall        (fall)
  );

  assign at_bit      = sample_tick && (tick_cnt == FULL_M1);
  assign start_frame = (state == ST_IDLE) && fall;

`ifdef UART_RX_BREAK_DET_EN
  logic brk_acc, brk_wait, brk_hit;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n      = state;
    shift        = 1'b0;
    parity_check = 1'b0;
    chk_stop     = 1'b0;
    done         = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
    brk_hit      = 1'b0;
`endif
    case (state)
      ST_IDLE:  if (start_frame) state_n = ST_START;
      ST_START: if (sample_tick && (tick_cnt == HALF_M1)) state_n = vote ? ST_IDLE : ST_DATA;
      ST_DATA: begin
        if (at_bit) begin
          shift = 1'b1;
          if (bit_cnt == LAST_DATA) state_n = (PARITY_MODE != PAR_NONE) ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (at_bit) begin
          parity_check = 1'b1;
          state_n      = ST_STOP;
        end
      end
      ST_STOP: begin
`ifdef UART_RX_BREAK_DET_EN
        // after a break the line must recover before another start edge is accepted
        if (brk_wait) begin
          if (sample_tick && vote) state_n = ST_IDLE;
        end else if (at_bit) begin
          chk_stop = 1'b1;
          if (bit_cnt == LAST_STOP) begin
            if (brk_acc && !vote) begin
              brk_hit = 1'b1;
            end else begin
              done    = 1'b1;
              state_n = ST_IDLE;
            end
          end
        end
`else
        if (at_bit) begin
          chk_stop = 1'b1;
          if (bit_cnt == LAST_STOP) begin
            done    = 1'b1;
            state_n = ST_IDLE;
          end
        end
`endif
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      par_acc    <= 1'b0;
      frm_acc    <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= done;
      if (sample_tick) begin
        if ((state == ST_IDLE) || ((state == ST_START) && (tick_cnt == HALF_M1)) ||
            (tick_cnt == FULL_M1))
          tick_cnt <= '0;
        else
          tick_cnt <= tick_cnt + TW'(1);
      end
      if (state_n != state)          bit_cnt <= '0;
      else if (shift || chk_stop)    bit_cnt <= bit_cnt + BW'(1);
      if (shift) shift_reg <= {vote, shift_reg[DATA_BITS-1:1]};
      if (start_frame) begin
        par_acc <= 1'b0;
        frm_acc <= 1'b0;
      end
      if (parity_check)      par_acc <= vote ^ (^shift_reg) ^ ODD_INV;
      if (chk_stop && !vote) frm_acc <= 1'b1;
      if (done) begin
        data_out   <= shift_reg;
        parity_err <= par_acc;
        frame_err  <= frm_acc | ~vote;
      end
    end
  end

`ifdef UART_RX_BREAK_DET_EN
  // brk_acc stays set only while every sample of the frame has been low
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      brk_acc   <= 1'b0;
      brk_wait  <= 1'b0;
      break_det <= 1'b0;
    end else begin
      break_det <= brk_hit;
      if (start_frame)                           brk_acc <= 1'b1;
      else if (shift || parity_check || chk_stop) brk_acc <= brk_acc & ~vote;
      if (brk_hit)                   brk_wait <= 1'b1;
      else if (state_n == ST_IDLE)   brk_wait <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - bench for uart_rx_ctrl with 8N1, 8E1 and 7O2 instances

module tb_uart_rx_ctrl;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic sample_tick = 1'b0;
  logic rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;
  logic shift_a, pc_a, cs_a, dv_a, pe_a, fe_a;
  logic shift_b, pc_b, cs_b, dv_b, pe_b, fe_b;
  logic shift_c, pc_c, cs_c, dv_c, pe_c, fe_c;
  logic [7:0] do_a, do_b;
  logic [6:0] do_c;
`ifdef UART_RX_BREAK_DET_EN
  logic brk_a, brk_b, brk_c;
`endif

  int n_cmp = 0, n_bad = 0;
  int n_shift[3], n_pc[3], n_cs[3], n_dv[3], n_brk[3], n_multi[3];
  logic [8:0] cap_data[3];
  logic       cap_pe[3], cap_fe[3];
  int b_shift, b_pc, b_cs, b_dv, b_brk, b_multi;

  always #5 clk = ~clk;

  uart_rx_ctrl #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_MODE(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .reset_n(reset_n), .sample_tick(sample_tick), .rx(rx_a),
    .shift(shift_a), .parity_check(pc_a), .chk_stop(cs_a), .data_out(do_a),
    .data_valid(dv_a), .parity_err(pe_a), .frame_err(fe_a)
`ifdef UART_RX_BREAK_DET_EN
    , .break_det(brk_a)
`endif
  );

  uart_rx_ctrl #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_MODE(1), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .reset_n(reset_n), .sample_tick(sample_tick), .rx(rx_b),
    .shift(shift_b), .parity_check(pc_b), .chk_stop(cs_b), .data_out(do_b),
    .data_valid(dv_b), .parity_err(pe_b), .frame_err(fe_b)
`ifdef UART_RX_BREAK_DET_EN
    , .break_det(brk_b)
`endif
  );

  uart_rx_ctrl #(.DATA_BITS(7), .OVERSAMPLE(16), .PARITY_MODE(2), .STOP_BITS(2)) u_7o2 (
    .clk(clk), .reset_n(reset_n), .sample_tick(sample_tick), .rx(rx_c),
    .shift(shift_c), .parity_check(pc_c), .chk_stop(cs_c), .data_out(do_c),
    .data_valid(dv_c), .parity_err(pe_c), .frame_err(fe_c)
`ifdef UART_RX_BREAK_DET_EN
    , .break_det(brk_c)
`endif
  );

  logic [2:0] m_sh, m_pc, m_cs, m_dv, m_pe, m_fe, m_brk;
  assign m_sh = {shift_c, shift_b, shift_a};
  assign m_pc = {pc_c, pc_b, pc_a};
  assign m_cs = {cs_c, cs_b, cs_a};
  assign m_dv = {dv_c, dv_b, dv_a};
  assign m_pe = {pe_c, pe_b, pe_a};
  assign m_fe = {fe_c, fe_b, fe_a};
`ifdef UART_RX_BREAK_DET_EN
  assign m_brk = {brk_c, brk_b, brk_a};
`else
  assign m_brk = 3'b000;
`endif

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (m_sh[i])  n_shift[i] <= n_shift[i] + 1;
      if (m_pc[i])  n_pc[i]    <= n_pc[i] + 1;
      if (m_cs[i])  n_cs[i]    <= n_cs[i] + 1;
      if (m_brk[i]) n_brk[i]   <= n_brk[i] + 1;
      if ((32'(m_sh[i]) + 32'(m_pc[i]) + 32'(m_cs[i])) > 1) n_multi[i] <= n_multi[i] + 1;
      if (m_dv[i]) begin
        n_dv[i]   <= n_dv[i] + 1;
        cap_pe[i] <= m_pe[i];
        cap_fe[i] <= m_fe[i];
      end
    end
    if (dv_a) cap_data[0] <= 9'(do_a);
    if (dv_b) cap_data[1] <= 9'(do_b);
    if (dv_c) cap_data[2] <= 9'(do_c);
  end

  initial begin
    forever begin
      repeat (3) @(negedge clk);
      sample_tick = 1'b1;
      @(negedge clk);
      sample_tick = 1'b0;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic mark(input int i);
    b_shift = n_shift[i]; b_pc = n_pc[i]; b_cs = n_cs[i];
    b_dv = n_dv[i]; b_brk = n_brk[i]; b_multi = n_multi[i];
  endtask

  task automatic set_rx(input int i, input logic v);
    case (i)
      0: rx_a = v;
      1: rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  task automatic bit_time(input int i, input logic v);
    set_rx(i, v);
    repeat (64) @(negedge clk);
  endtask

  task automatic send_frame(input int i, input logic [8:0] d, input logic pbit, input logic [1:0] stops);
    int nbits, nstop;
    nbits = (i == 2) ? 7 : 8;
    nstop = (i == 2) ? 2 : 1;
    bit_time(i, 1'b0);
    for (int k = 0; k < nbits; k++) bit_time(i, d[k]);
    if (i != 0) bit_time(i, pbit);
    for (int k = 0; k < nstop; k++) bit_time(i, stops[k]);
  endtask

  // reference rules: parity bit must equal XOR of data (even) or its inverse (odd)
  function automatic logic ref_pe(input int pmode, input logic [8:0] d, input int nbits, input logic pbit);
    int ones;
    ones = 0;
    for (int k = 0; k < nbits; k++) ones += int'(d[k]);
    if (pmode == 0) return 1'b0;
    if (pmode == 1) return pbit != logic'(ones % 2);
    return pbit != logic'((ones + 1) % 2);
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (6) @(negedge clk);
    n_cmp++; if (m_dv !== 3'b000) begin n_bad++; $display("FAIL reset_dv: got %b want 000", m_dv); end
    n_cmp++; if ({m_sh, m_pc, m_cs} !== 9'd0) begin n_bad++; $display("FAIL reset_pulses: got %b want 0", {m_sh, m_pc, m_cs}); end
    n_cmp++; if ({m_pe, m_fe} !== 6'd0) begin n_bad++; $display("FAIL reset_err: got %b want 0", {m_pe, m_fe}); end
    n_cmp++; if ({do_a, do_b, do_c} !== 23'd0) begin n_bad++; $display("FAIL reset_data: got %h want 0", {do_a, do_b, do_c}); end
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
  endtask

  task automatic test_8n1();
    mark(0);
    send_frame(0, 9'h0A5, 1'b0, 2'b11);
    bit_time(0, 1'b1);
    n_cmp++; if (n_shift[0] - b_shift !== 8) begin n_bad++; $display("FAIL 8n1_shift: got %0d want 8", n_shift[0] - b_shift); end
    n_cmp++; if (n_cs[0] - b_cs !== 1) begin n_bad++; $display("FAIL 8n1_chk_stop: got %0d want 1", n_cs[0] - b_cs); end
    n_cmp++; if (n_pc[0] - b_pc !== 0) begin n_bad++; $display("FAIL 8n1_parity_check: got %0d want 0", n_pc[0] - b_pc); end
    n_cmp++; if (n_dv[0] - b_dv !== 1) begin n_bad++; $display("FAIL 8n1_dv_cycles: got %0d want 1", n_dv[0] - b_dv); end
    n_cmp++; if (cap_data[0] !== 9'h0A5) begin n_bad++; $display("FAIL 8n1_data: got %h want a5", cap_data[0]); end
    n_cmp++; if ({cap_pe[0], cap_fe[0]} !== 2'b00) begin n_bad++; $display("FAIL 8n1_err: got %b want 00", {cap_pe[0], cap_fe[0]}); end
    n_cmp++; if (do_a !== 8'hA5) begin n_bad++; $display("FAIL 8n1_data_hold: got %h want a5", do_a); end
  endtask

  task automatic test_8e1_bad_parity();
    mark(1);
    send_frame(1, 9'h007, 1'b0, 2'b11);
    bit_time(1, 1'b1);
    n_cmp++; if (n_pc[1] - b_pc !== 1) begin n_bad++; $display("FAIL 8e1_parity_check: got %0d want 1", n_pc[1] - b_pc); end
    n_cmp++; if (n_dv[1] - b_dv !== 1) begin n_bad++; $display("FAIL 8e1_dv: got %0d want 1", n_dv[1] - b_dv); end
    n_cmp++; if (cap_data[1] !== 9'h007) begin n_bad++; $display("FAIL 8e1_data: got %h want 07", cap_data[1]); end
    n_cmp++; if ({cap_pe[1], cap_fe[1]} !== 2'b10) begin n_bad++; $display("FAIL 8e1_err: got %b want 10", {cap_pe[1], cap_fe[1]}); end
    n_cmp++; if (pe_b !== 1'b1) begin n_bad++; $display("FAIL 8e1_pe_hold: got %b want 1", pe_b); end
  endtask

  task automatic test_7o2_bad_stop();
    mark(2);
    send_frame(2, 9'h055, 1'b1, 2'b01);
    bit_time(2, 1'b1);
    n_cmp++; if (n_cs[2] - b_cs !== 2) begin n_bad++; $display("FAIL 7o2_chk_stop: got %0d want 2", n_cs[2] - b_cs); end
    n_cmp++; if (n_shift[2] - b_shift !== 7) begin n_bad++; $display("FAIL 7o2_shift: got %0d want 7", n_shift[2] - b_shift); end
    n_cmp++; if (cap_data[2] !== 9'h055) begin n_bad++; $display("FAIL 7o2_data: got %h want 55", cap_data[2]); end
    n_cmp++; if ({cap_pe[2], cap_fe[2]} !== 2'b01) begin n_bad++; $display("FAIL 7o2_err: got %b want 01", {cap_pe[2], cap_fe[2]}); end
  endtask

  task automatic test_glitch();
    mark(0);
    set_rx(0, 1'b0);
    repeat (20) @(negedge clk);
    set_rx(0, 1'b1);
    repeat (192) @(negedge clk);
    n_cmp++; if (n_shift[0] - b_shift !== 0) begin n_bad++; $display("FAIL glitch_shift: got %0d want 0", n_shift[0] - b_shift); end
    n_cmp++; if (n_dv[0] - b_dv !== 0) begin n_bad++; $display("FAIL glitch_dv: got %0d want 0", n_dv[0] - b_dv); end
    n_cmp++; if (n_cs[0] - b_cs !== 0) begin n_bad++; $display("FAIL glitch_chk_stop: got %0d want 0", n_cs[0] - b_cs); end
  endtask

  task automatic test_reset_mid_frame();
    mark(0);
    bit_time(0, 1'b0);
    for (int k = 0; k < 4; k++) bit_time(0, 1'b1);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (dv_a !== 1'b0) begin n_bad++; $display("FAIL midreset_dv_low: got %b want 0", dv_a); end
    reset_n = 1'b1;
    for (int k = 0; k < 5; k++) bit_time(0, 1'b1);
    send_frame(0, 9'h03C, 1'b0, 2'b11);
    bit_time(0, 1'b1);
    n_cmp++; if (n_dv[0] - b_dv !== 1) begin n_bad++; $display("FAIL midreset_dv: got %0d want 1", n_dv[0] - b_dv); end
    n_cmp++; if (cap_data[0] !== 9'h03C) begin n_bad++; $display("FAIL midreset_data: got %h want 3c", cap_data[0]); end
    n_cmp++; if (n_shift[0] - b_shift !== 12) begin n_bad++; $display("FAIL midreset_shift: got %0d want 12", n_shift[0] - b_shift); end
  endtask

  task automatic test_break();
    mark(0);
    set_rx(0, 1'b0);
    repeat (12 * 64) @(negedge clk);
    set_rx(0, 1'b1);
    repeat (128) @(negedge clk);
`ifdef UART_RX_BREAK_DET_EN
    n_cmp++; if (n_brk[0] - b_brk !== 1) begin n_bad++; $display("FAIL break_det: got %0d want 1", n_brk[0] - b_brk); end
    n_cmp++; if (n_dv[0] - b_dv !== 0) begin n_bad++; $display("FAIL break_dv: got %0d want 0", n_dv[0] - b_dv); end
`else
    n_cmp++; if (n_dv[0] - b_dv !== 1) begin n_bad++; $display("FAIL break_dv: got %0d want 1", n_dv[0] - b_dv); end
    n_cmp++; if (cap_data[0] !== 9'h000) begin n_bad++; $display("FAIL break_data: got %h want 00", cap_data[0]); end
    n_cmp++; if ({cap_pe[0], cap_fe[0]} !== 2'b01) begin n_bad++; $display("FAIL break_err: got %b want 01", {cap_pe[0], cap_fe[0]}); end
`endif
  endtask

  task automatic test_back_to_back();
    logic [8:0] d0, d1;
    d0 = 9'($urandom_range(1, 255));
    d1 = 9'($urandom_range(1, 255));
    mark(0);
    send_frame(0, d0, 1'b0, 2'b11);
    send_frame(0, d1, 1'b0, 2'b11);
    bit_time(0, 1'b1);
    n_cmp++; if (n_dv[0] - b_dv !== 2) begin n_bad++; $display("FAIL b2b_dv: got %0d want 2", n_dv[0] - b_dv); end
    n_cmp++; if (cap_data[0] !== d1) begin n_bad++; $display("FAIL b2b_data: got %h want %h", cap_data[0], d1); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3; i++) begin
      for (int n = 0; n < 6; n++) begin
        int nbits, nstop;
        logic [8:0] d, mask;
        logic pbit, exp_pe, exp_fe, exp_brk;
        logic [1:0] stops;
        nbits = (i == 2) ? 7 : 8;
        nstop = (i == 2) ? 2 : 1;
        mask  = 9'((1 << nbits) - 1);
        d     = 9'($urandom) & mask;
        pbit  = 1'($urandom);
        stops = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
        exp_pe = ref_pe(i, d, nbits, pbit);
        exp_fe = (stops[0] == 1'b0) || ((nstop == 2) && (stops[1] == 1'b0));
`ifdef UART_RX_BREAK_DET_EN
        exp_brk = (d == 9'd0) && ((i == 0) || !pbit) && (stops[0] == 1'b0) && ((nstop == 1) || (stops[1] == 1'b0));
`else
        exp_brk = 1'b0;
`endif
        mark(i);
        send_frame(i, d, pbit, stops);
        bit_time(i, 1'b1);
        n_cmp++; if (n_dv[i] - b_dv !== (exp_brk ? 0 : 1)) begin n_bad++; $display("FAIL rnd%0d_dv: got %0d want %0d", i, n_dv[i] - b_dv, exp_brk ? 0 : 1); end
        n_cmp++; if (n_shift[i] - b_shift !== nbits) begin n_bad++; $display("FAIL rnd%0d_shift: got %0d want %0d", i, n_shift[i] - b_shift, nbits); end
        n_cmp++; if (n_cs[i] - b_cs !== nstop) begin n_bad++; $display("FAIL rnd%0d_chk_stop: got %0d want %0d", i, n_cs[i] - b_cs, nstop); end
        n_cmp++; if (n_pc[i] - b_pc !== ((i != 0) ? 1 : 0)) begin n_bad++; $display("FAIL rnd%0d_parity_check: got %0d want %0d", i, n_pc[i] - b_pc, (i != 0) ? 1 : 0); end
        n_cmp++; if (n_multi[i] - b_multi !== 0) begin n_bad++; $display("FAIL rnd%0d_exclusive: got %0d want 0", i, n_multi[i] - b_multi); end
        if (!exp_brk) begin
          n_cmp++; if (cap_data[i] !== d) begin n_bad++; $display("FAIL rnd%0d_data: got %h want %h", i, cap_data[i], d); end
          n_cmp++; if ({cap_pe[i], cap_fe[i]} !== {exp_pe, exp_fe}) begin n_bad++; $display("FAIL rnd%0d_err: got %b want %b", i, {cap_pe[i], cap_fe[i]}, {exp_pe, exp_fe}); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_8e1_bad_parity();
    test_7o2_bad_stop();
    test_glitch();
    test_reset_mid_frame();
    test_break();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter DATA_BITS, default 8: data bits per frame, legal range 5..9.
REQ-002 Parameter OVERSAMPLE, default 16: sample_tick pulses per bit, even, legal range 8..32.
REQ-003 Parameter PARITY_MODE, default 0: 0 none, 1 even, 2 odd.
REQ-004 Parameter STOP_BITS, default 1: stop bits per frame, legal values 1 or 2.
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 sample_tick  in  1  one-cycle enable at OVERSAMPLE x baud rate.
REQ-008 rx  in  1  serial line, asynchronous, idle high.
REQ-009 shift  out  1  one-cycle pulse per sampled data bit.
REQ-010 parity_check  out  1  one-cycle pulse when the parity bit is sampled.
REQ-011 chk_stop  out  1  one-cycle pulse per sampled stop bit.
REQ-012 data_out  out  DATA_BITS  received word, LSB first on the line.
REQ-013 data_valid  out  1  one-cycle pulse when a frame completes.
REQ-014 parity_err  out  1  parity mismatch, qualified by data_valid.
REQ-015 frame_err  out  1  stop bit sampled low, qualified by data_valid.

Function
REQ-016 rx passes through a 2-flop synchronizer; every FSM decision uses only the synchronized value.
REQ-017 FSM states: IDLE, START, DATA, PARITY, STOP. The tick counter and bit counter advance only on sample_tick.
REQ-018 IDLE -> START on a synchronized 1->0 transition of rx; the tick counter clears.
REQ-019 START: at tick OVERSAMPLE/2-1, a 3-sample majority vote of rx is taken. Result 0 -> DATA with counters cleared. Result 1 -> false start, return to IDLE with no output pulses.
REQ-020 DATA: each bit is sampled by majority vote every OVERSAMPLE ticks. The sample shifts into the MSB of the shift register, and shift pulses in the same cycle. After DATA_BITS samples the FSM moves to PARITY if PARITY_MODE is not 0, otherwise to STOP.
REQ-021 PARITY: one bit is sampled and parity_check pulses. Computed parity is the XOR of the data bits, inverted for odd mode. parity_err latches the mismatch.
REQ-022 STOP: STOP_BITS samples are taken, with chk_stop pulsing on each. Any stop sample of 0 sets frame_err.
REQ-023 After the final stop sample, on the next clk:
- data_out loads from the shift register and holds until the next frame completes;
- data_valid pulses for exactly one cycle;
- the FSM enters IDLE.
REQ-024 Frames with parity_err or frame_err still deliver data_valid. Both error flags hold until the next data_valid.
REQ-025 At most one of shift, parity_check and chk_stop is high in any cycle.
REQ-026 Latency from the last stop sample to data_valid is 1 cycle. A new frame may start in the cycle after data_valid.
REQ-027 With sample_tick held low, all state and outputs freeze; pulse outputs stay 0.

Reset
REQ-028 reset_n low asynchronously forces:
- FSM to IDLE;
- all counters and the shift register to 0;
- both synchronizer flops to 1;
- data_out to 0;
- shift, parity_check, chk_stop, data_valid, parity_err and frame_err to 0.
REQ-029 Reset mid-frame discards the partial frame and produces no data_valid. The first frame after release requires a fresh falling edge.

Configuration
REQ-030 With UART_RX_BREAK_DET_EN defined: output break_det (1 bit) pulses once when rx has been low for a whole frame with data all 0 and stop 0. In that case data_valid is suppressed, and the FSM waits in STOP until rx returns high before entering IDLE.
REQ-031 Without UART_RX_BREAK_DET_EN: the break_det port does not exist, and a break frame is reported as data 0 with frame_err=1.

Structure
REQ-032 Package uart_pkg holds the FSM state enum, the PARITY_MODE constants (PAR_NONE, PAR_EVEN, PAR_ODD) and a parameter legality check function.
REQ-033 Sub-module uart_rx_sampler contains the 2-flop synchronizer, the 3-sample majority vote and falling-edge detection.

Verification
REQ-034 The bench drives sample_tick as 1 pulse every 4 clk with OVERSAMPLE=16, and covers these scenarios:
- 8N1, byte 0xA5 -> 8 shift pulses, 1 chk_stop, data_out=0xA5, data_valid=1 for 1 cycle, no errors.
- 8E1, byte 0x07 with wrong parity bit 0 -> parity_check pulses, data_out=0x07, parity_err=1.
- 7O2, byte 0x55 with second stop bit 0 -> 2 chk_stop pulses, frame_err=1, data_out=0x55.
- rx low for 5 ticks, then high (glitch) -> FSM back to IDLE; no shift and no data_valid.
- reset_n asserted after the 4th data bit of 0xFF, then a clean frame 0x3C -> only the 0x3C frame produces data_valid.
- rx held low for 12 bit times -> with UART_RX_BREAK_DET_EN, break_det=1 and no data_valid; without it, data 0x00 with frame_err=1.
